// File: rtl/trace_bus_writer.sv
// trace_bus_writer: timestamps profiling events, buffers them and writes 2-word records
// (w0 = {end, 23'd0, id}, w1 = cycle count) into a word ring in memory over the host bus.
// Latency: event captured in its strobe cycle; first request 2 cycles later; >= 4 cycles/record.
// Backpressure: none upstream; events that cannot be buffered are counted in drop_cnt_o.
// Ports: clk_i/rst_ni (async active-low); en_i, evt_valid_i, evt_id_i, evt_end_i event input;
//        host_* simple-system bus initiator (one outstanding write); wr_ptr_o ring word index;
//        drop_cnt_o saturating drop count; err_o sticky bus error; full_o ring exhausted.
// Build option TRACE_WRAP_EN: ring wraps forever (full_o tied 0); when undefined the ring
// stops after one pass, full_o sets and all later events are dropped.

// trace_fifo: generic first-word-fall-through FIFO.
// Latency: pushed word visible at head the cycle after push.
// Backpressure: caller must not push when count == Depth unless popping in the same cycle.
module trace_fifo #(
    parameter int Width = 64,
    parameter int Depth = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_vld,
    input  logic [Width-1:0]       push_dat,
    input  logic                   pop_vld,
    output logic [Width-1:0]       head_dat,
    output logic [$clog2(Depth):0] count
);
    localparam int Aw = $clog2(Depth);

    logic [Width-1:0] mem [Depth];
    logic [Aw-1:0]    rd_ptr;
    logic [Aw-1:0]    wr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + Aw'(1);
            if (pop_vld)  rd_ptr <= rd_ptr + Aw'(1);
            case ({push_vld, pop_vld})
                2'b10:   count <= count + (Aw+1)'(1);
                2'b01:   count <= count - (Aw+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: head is only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push_vld) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
endmodule

module trace_bus_writer #(
    parameter logic [31:0] BufBase   = 32'h0010_0000,
    parameter int          BufWords  = 256,
    parameter int          FifoDepth = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        en_i,
    input  logic                        evt_valid_i,
    input  logic [7:0]                  evt_id_i,
    input  logic                        evt_end_i,
    output logic                        host_req_o,
    input  logic                        host_gnt_i,
    output logic                        host_we_o,
    output logic [3:0]                  host_be_o,
    output logic [31:0]                 host_addr_o,
    output logic [31:0]                 host_wdata_o,
    input  logic                        host_rvalid_i,
    input  logic                        host_err_i,
    output logic [$clog2(BufWords)-1:0] wr_ptr_o,
    output logic [15:0]                 drop_cnt_o,
    output logic                        err_o,
    output logic                        full_o
);
    localparam int PtrW = $clog2(BufWords);
    localparam int CntW = $clog2(FifoDepth) + 1;

    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [31:0]     cyc_cnt;
    logic [CntW-1:0] fifo_cnt;
    logic [63:0]     head_dat;
    logic            pop;
    logic            push;
    logic            drop;
    logic            can_push;
    logic            more;
    logic            ring_last;
    logic [PtrW-1:0] ptr_odd;

    // A record retires when its second word is acknowledged.
    assign pop = (state == WAIT1) && host_rvalid_i;

    // A full FIFO still takes an event in the cycle its head retires.
    assign can_push = !full_o && ((fifo_cnt != CntW'(FifoDepth)) || pop);
    assign push     = evt_valid_i && en_i && can_push;
    assign drop     = evt_valid_i && en_i && !can_push;
    assign more     = (fifo_cnt > CntW'(1)) || push;

`ifdef TRACE_WRAP_EN
    assign ring_last = 1'b0;
    assign full_o    = 1'b0;
`else
    // Without wrapping, the record at the last slot pair ends the capture for good.
    assign ring_last = (wr_ptr_o == PtrW'(BufWords - 2));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)               full_o <= 1'b0;
        else if (pop && ring_last) full_o <= 1'b1;
    end
`endif

    trace_fifo #(.Width(64), .Depth(FifoDepth)) u_fifo (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .push_vld (push),
        .push_dat ({cyc_cnt, evt_end_i, 23'd0, evt_id_i}),
        .pop_vld  (pop),
        .head_dat (head_dat),
        .count    (fifo_cnt)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cyc_cnt    <= '0;
            wr_ptr_o   <= '0;
            drop_cnt_o <= '0;
            err_o      <= 1'b0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if (pop) wr_ptr_o <= wr_ptr_o + PtrW'(2);
            if (drop && (drop_cnt_o != 16'hFFFF)) drop_cnt_o <= drop_cnt_o + 16'd1;
            if (host_rvalid_i && host_err_i) err_o <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if ((fifo_cnt != '0) && !full_o) state_nxt = REQ0;
            REQ0:    if (host_gnt_i) state_nxt = WAIT0;
            WAIT0:   if (host_rvalid_i) state_nxt = REQ1;
            REQ1:    if (host_gnt_i) state_nxt = WAIT1;
            WAIT1:   if (host_rvalid_i) state_nxt = (more && !ring_last) ? REQ0 : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // wr_ptr_o is always even, so the second word's index is wr_ptr_o with bit 0 set.
    assign ptr_odd = {wr_ptr_o[PtrW-1:1], 1'b1};

    // Request outputs depend only on state, pointer and FIFO head, all of which hold
    // still until the grant, so the bus sees stable address/data while waiting.
    always_comb begin
        host_req_o   = 1'b0;
        host_we_o    = 1'b0;
        host_be_o    = 4'h0;
        host_addr_o  = 32'h0;
        host_wdata_o = 32'h0;
        unique case (state)
            REQ0: begin
                host_req_o   = 1'b1;
                host_we_o    = 1'b1;
                host_be_o    = 4'hF;
                host_addr_o  = BufBase + 32'({wr_ptr_o, 2'b00});
                host_wdata_o = head_dat[31:0];
            end
            REQ1: begin
                host_req_o   = 1'b1;
                host_we_o    = 1'b1;
                host_be_o    = 4'hF;
                host_addr_o  = BufBase + 32'({ptr_odd, 2'b00});
                host_wdata_o = head_dat[63:32];
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_trace_bus_writer.sv
module tb_trace_bus_writer;
    localparam logic [31:0] BASE = 32'h0010_0000;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0, en_s = 1'b0;
    logic evt_valid = 1'b0, evt_end = 1'b0;
    logic [7:0] evt_id = 8'h0;

    logic req, gnt, we, rvalid, rsp_err, err_flag, full;
    logic [3:0] be;
    logic [31:0] addr, wdata;
    logic [7:0] wr_ptr;
    logic [15:0] drop_cnt;

    logic req_s, gnt_s, we_s, rvalid_s, err_s, full_s;
    logic [3:0] be_s;
    logic [31:0] addr_s, wdata_s;
    logic [1:0] wr_ptr_s;
    logic [15:0] drop_s;

    int checks = 0, errors = 0;
    logic [31:0] tb_cyc;

    // responder configuration (written by tests) and state (written by responders)
    int gnt_dly = 0, rv_dly = 0, err_rsp_idx = -1;
    bit pend, pend_s;
    int wcnt, rcnt, nwr, rsp_n, retired, viol, viol_s;
    logic [31:0] ref_a, ref_d;
    logic [31:0] log_addr[$], log_dat[$], log_s_addr[$], log_s_dat[$];
    int reqlen[$];

    // reference model state (written by tests)
    int pushed, mptr, exp_drops;
    logic [31:0] exp_addr[$], exp_dat[$];

    always #5 clk = ~clk;

    trace_bus_writer dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .evt_valid_i(evt_valid), .evt_id_i(evt_id),
        .evt_end_i(evt_end), .host_req_o(req), .host_gnt_i(gnt), .host_we_o(we), .host_be_o(be),
        .host_addr_o(addr), .host_wdata_o(wdata), .host_rvalid_i(rvalid), .host_err_i(rsp_err),
        .wr_ptr_o(wr_ptr), .drop_cnt_o(drop_cnt), .err_o(err_flag), .full_o(full)
    );

    trace_bus_writer #(.BufWords(4)) dut_s (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en_s), .evt_valid_i(evt_valid), .evt_id_i(evt_id),
        .evt_end_i(evt_end), .host_req_o(req_s), .host_gnt_i(gnt_s), .host_we_o(we_s),
        .host_be_o(be_s), .host_addr_o(addr_s), .host_wdata_o(wdata_s), .host_rvalid_i(rvalid_s),
        .host_err_i(1'b0), .wr_ptr_o(wr_ptr_s), .drop_cnt_o(drop_s), .err_o(err_s), .full_o(full_s)
    );

    // Cycle count as seen by software: cycles since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cyc <= 32'd0;
        else        tb_cyc <= tb_cyc + 32'd1;
    end

    // Main responder: programmable grant / response delays, optional error on one response.
    always @(negedge clk) begin
        gnt = 1'b0; rvalid = 1'b0; rsp_err = 1'b0;
        if (!rst_n) begin
            pend = 0; wcnt = 0; rcnt = 0; nwr = 0; rsp_n = 0; retired = 0; viol = 0;
            log_addr.delete(); log_dat.delete(); reqlen.delete();
        end else if (pend) begin
            if (rcnt >= rv_dly) begin
                rvalid = 1'b1;
                rsp_err = (rsp_n == err_rsp_idx);
                rsp_n++; pend = 0;
                if (nwr % 2 == 0) retired++;
            end else rcnt++;
        end else if (req) begin
            if (wcnt == 0) begin ref_a = addr; ref_d = wdata; end
            else if (addr !== ref_a || wdata !== ref_d) viol++;
            if (we !== 1'b1 || be !== 4'hF) viol++;
            if (wcnt >= gnt_dly) begin
                gnt = 1'b1;
                log_addr.push_back(addr); log_dat.push_back(wdata); reqlen.push_back(wcnt + 1);
                wcnt = 0; rcnt = 0; pend = 1; nwr++;
            end else wcnt++;
        end
    end

    // Small-ring responder: zero-wait.
    always @(negedge clk) begin
        gnt_s = 1'b0; rvalid_s = 1'b0;
        if (!rst_n) begin
            pend_s = 0; viol_s = 0; log_s_addr.delete(); log_s_dat.delete();
        end else if (pend_s) begin
            rvalid_s = 1'b1; pend_s = 0;
        end else if (req_s) begin
            gnt_s = 1'b1;
            if (we_s !== 1'b1 || be_s !== 4'hF) viol_s++;
            log_s_addr.push_back(addr_s); log_s_dat.push_back(wdata_s); pend_s = 1;
        end
    end

    task automatic step();
        @(negedge clk); #1;
    endtask

    // Drive one cycle of event input and predict its fate for the main (256-word) instance.
    task automatic set_evt(input bit v, input bit end_f, input logic [7:0] id);
        evt_valid = v; evt_end = end_f; evt_id = id;
        if (v && en) begin
            if (pushed - retired < DEPTH) begin
                exp_addr.push_back(32'(BASE + 4 * mptr));
                exp_dat.push_back({end_f, 23'd0, id});
                exp_addr.push_back(32'(BASE + 4 * (mptr + 1)));
                exp_dat.push_back(tb_cyc);
                mptr = (mptr + 2) % 256;
                pushed++;
            end else exp_drops++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 0; en_s = 0; evt_valid = 0; evt_end = 0; evt_id = 0;
        gnt_dly = 0; rv_dly = 0; err_rsp_idx = -1;
        pushed = 0; mptr = 0; exp_drops = 0; exp_addr.delete(); exp_dat.delete();
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(output bit ok);
        int n = 0;
        while ((retired != pushed || req) && n < 3000) begin step(); n++; end
        ok = (n < 3000);
        repeat (3) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        checks++;
        if ({req, we, be, addr, wdata} !== '0) begin
            errors++; $display("FAIL reset_bus: got req=%b addr=%h wdata=%h, required all 0", req, addr, wdata);
        end
        checks++;
        if ({wr_ptr, drop_cnt, err_flag, full} !== '0) begin
            errors++; $display("FAIL reset_status: got ptr=%0d drop=%0d err=%b full=%b, required 0", wr_ptr, drop_cnt, err_flag, full);
        end
        checks++;
        if ({req_s, wr_ptr_s, drop_s, err_s, full_s} !== '0) begin
            errors++; $display("FAIL reset_small: small instance outputs not 0 (req=%b full=%b)", req_s, full_s);
        end
        do_reset();
        repeat (10) step();
        checks++;
        if (req !== 1'b0 || log_addr.size() != 0) begin
            errors++; $display("FAIL idle_no_req: got req=%b writes=%0d, required 0/0", req, log_addr.size());
        end
    endtask

    task automatic test_single();
        bit ok;
        do_reset(); en = 1;
        while (tb_cyc < 100) step();
        set_evt(1, 0, 8'h05);
        step(); set_evt(0, 0, 8'h00);
        wait_drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout: record never retired"); end
        checks++;
        if (log_addr.size() != 2) begin
            errors++; $display("FAIL single_count: got %0d writes, required 2", log_addr.size());
        end else begin
            checks++;
            if (log_addr[0] !== 32'h0010_0000 || log_dat[0] !== 32'h0000_0005) begin
                errors++; $display("FAIL single_w0: got %h @ %h, required 00000005 @ 00100000", log_dat[0], log_addr[0]);
            end
            checks++;
            if (log_addr[1] !== 32'h0010_0004 || log_dat[1] !== 32'd100) begin
                errors++; $display("FAIL single_w1: got %0d @ %h, required 100 @ 00100004", log_dat[1], log_addr[1]);
            end
        end
        checks++;
        if (wr_ptr !== 8'd2 || drop_cnt !== 16'd0) begin
            errors++; $display("FAIL single_status: got ptr=%0d drop=%0d, required 2/0", wr_ptr, drop_cnt);
        end
    endtask

    task automatic test_end_flag();
        bit ok;
        do_reset(); en = 1;
        step(); set_evt(1, 1, 8'h05);
        step(); set_evt(0, 0, 8'h00);
        wait_drain(ok);
        checks++;
        if (!ok || log_dat.size() != 2) begin
            errors++; $display("FAIL end_count: got %0d writes ok=%b, required 2", log_dat.size(), ok);
        end else begin
            checks++;
            if (log_dat[0] !== 32'h8000_0005) begin
                errors++; $display("FAIL end_w0: got %h, required 80000005", log_dat[0]);
            end
            checks++;
            if (log_dat[1] !== exp_dat[1]) begin
                errors++; $display("FAIL end_w1: got %0d, required %0d", log_dat[1], exp_dat[1]);
            end
        end
    endtask

    task automatic test_gnt_stall();
        bit ok;
        do_reset(); en = 1; gnt_dly = 5;
        step(); set_evt(1, 0, 8'h3C);
        step(); set_evt(0, 0, 8'h00);
        wait_drain(ok);
        checks++;
        if (!ok || reqlen.size() != 2 || log_addr.size() != 2) begin
            errors++; $display("FAIL stall_count: got %0d requests ok=%b, required 2", reqlen.size(), ok);
        end else begin
            checks++;
            if (reqlen[0] != 6 || reqlen[1] != 6) begin
                errors++; $display("FAIL stall_len: got %0d/%0d request cycles, required 6/6", reqlen[0], reqlen[1]);
            end
            checks++;
            if (log_dat[0] !== 32'h0000_003C || log_dat[1] !== exp_dat[1]) begin
                errors++; $display("FAIL stall_data: got %h/%h, required 0000003c/%h", log_dat[0], log_dat[1], exp_dat[1]);
            end
        end
        checks++;
        if (viol != 0) begin
            errors++; $display("FAIL stall_stable: got %0d unstable request cycles, required 0", viol);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        do_reset(); en = 1; gnt_dly = 3; rv_dly = 3;
        for (int i = 0; i < 7; i++) begin
            step(); set_evt(1, 1'($urandom), 8'($urandom));
        end
        step(); set_evt(0, 0, 8'h00);
        wait_drain(ok);
        checks++;
        if (!ok || log_addr.size() != 8 || exp_addr.size() != 8) begin
            errors++; $display("FAIL burst_count: got %0d writes ok=%b, required 8", log_addr.size(), ok);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (log_addr[i] !== exp_addr[i] || log_dat[i] !== exp_dat[i]) begin
                    errors++; $display("FAIL burst_write%0d: got %h @ %h, required %h @ %h", i, log_dat[i], log_addr[i], exp_dat[i], exp_addr[i]);
                end
            end
        end
        checks++;
        if (drop_cnt !== 16'd3 || wr_ptr !== 8'd8) begin
            errors++; $display("FAIL burst_status: got drop=%0d ptr=%0d, required 3/8", drop_cnt, wr_ptr);
        end
    endtask

    task automatic test_bus_error();
        bit ok;
        do_reset(); en = 1; err_rsp_idx = 0;
        step(); set_evt(1, 0, 8'h11);
        step(); set_evt(0, 0, 8'h00);
        wait_drain(ok);
        checks++;
        if (err_flag !== 1'b1 || log_addr.size() != 2) begin
            errors++; $display("FAIL err_set: got err=%b writes=%0d, required 1/2", err_flag, log_addr.size());
        end
        for (int i = 0; i < 2; i++) begin
            step(); set_evt(1, 0, 8'(8'h20 + i));
            step(); set_evt(0, 0, 8'h00);
        end
        wait_drain(ok);
        checks++;
        if (!ok || err_flag !== 1'b1 || log_addr.size() != 6) begin
            errors++; $display("FAIL err_sticky: got err=%b writes=%0d ok=%b, required 1/6", err_flag, log_addr.size(), ok);
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (log_addr[i] !== exp_addr[i] || log_dat[i] !== exp_dat[i]) begin
                    errors++; $display("FAIL err_write%0d: got %h @ %h, required %h @ %h", i, log_dat[i], log_addr[i], exp_dat[i], exp_addr[i]);
                end
            end
        end
        rst_n = 1'b0; #1;
        checks++;
        if (err_flag !== 1'b0) begin
            errors++; $display("FAIL err_clear: got err=%b in reset, required 0", err_flag);
        end
    endtask

    task automatic test_random();
        bit ok;
        for (int round = 0; round < 2; round++) begin
            do_reset();
            gnt_dly = $urandom_range(0, 2); rv_dly = $urandom_range(0, 2);
            for (int c = 0; c < 300; c++) begin
                step();
                en = ($urandom % 8) != 0;
                set_evt(($urandom % 3) == 0, 1'($urandom), 8'($urandom));
            end
            step(); set_evt(0, 0, 8'h00);
            wait_drain(ok);
            checks++;
            if (!ok || log_addr.size() != exp_addr.size()) begin
                errors++; $display("FAIL rand_count: got %0d writes ok=%b, required %0d", log_addr.size(), ok, exp_addr.size());
            end else begin
                for (int i = 0; i < exp_addr.size(); i++) begin
                    checks++;
                    if (log_addr[i] !== exp_addr[i] || log_dat[i] !== exp_dat[i]) begin
                        errors++; $display("FAIL rand_write%0d: got %h @ %h, required %h @ %h", i, log_dat[i], log_addr[i], exp_dat[i], exp_addr[i]);
                    end
                end
            end
            checks++;
            if (drop_cnt !== 16'(exp_drops) || wr_ptr !== 8'(mptr)) begin
                errors++; $display("FAIL rand_status: got drop=%0d ptr=%0d, required %0d/%0d", drop_cnt, wr_ptr, exp_drops, mptr);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset(); en_s = 1;
        for (int r = 0; r < 3; r++) begin
            step(); set_evt(1, 0, 8'(r + 1));
            step(); set_evt(0, 0, 8'h00);
            repeat (20) step();
`ifndef TRACE_WRAP_EN
            if (r == 1) begin
                checks++;
                if (full_s !== 1'b1 || log_s_addr.size() != 4) begin
                    errors++; $display("FAIL nowrap_full: got full=%b writes=%0d after 2 records, required 1/4", full_s, log_s_addr.size());
                end
            end
`endif
        end
`ifdef TRACE_WRAP_EN
        checks++;
        if (log_s_addr.size() != 6) begin
            errors++; $display("FAIL wrap_count: got %0d writes, required 6", log_s_addr.size());
        end else begin
            checks++;
            if (log_s_addr[4] !== 32'h0010_0000 || log_s_dat[4] !== 32'h0000_0003) begin
                errors++; $display("FAIL wrap_third: got %h @ %h, required 00000003 @ 00100000", log_s_dat[4], log_s_addr[4]);
            end
        end
        checks++;
        if (wr_ptr_s !== 2'd2 || full_s !== 1'b0 || drop_s !== 16'd0) begin
            errors++; $display("FAIL wrap_status: got ptr=%0d full=%b drop=%0d, required 2/0/0", wr_ptr_s, full_s, drop_s);
        end
`else
        checks++;
        if (log_s_addr.size() != 4 || req_s !== 1'b0) begin
            errors++; $display("FAIL nowrap_noreq: got %0d writes req=%b, required 4/0", log_s_addr.size(), req_s);
        end
        checks++;
        if (full_s !== 1'b1 || drop_s !== 16'd1 || wr_ptr_s !== 2'd0) begin
            errors++; $display("FAIL nowrap_status: got full=%b drop=%0d ptr=%0d, required 1/1/0", full_s, drop_s, wr_ptr_s);
        end
`endif
        checks++;
        if (viol_s != 0 || err_s !== 1'b0) begin
            errors++; $display("FAIL small_bus: got %0d bad we/be cycles err=%b, required 0/0", viol_s, err_s);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_end_flag();
        test_gnt_stall();
        test_back_to_back();
        test_bus_error();
        test_random();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
